mul_arbiter: RTL and testbench

- Round-robin scheduler that shares one sequential shift-add multiplier between NREQ requesters.
- Latches the granted requester's operands and pulses the multiplier's init.
- Waits for done, then returns the product to that requester with a one-cycle ack.
- Sits between client blocks and the single multiplier instance; adds a watchdog timeout and post-reset resynchronisation.

---
 rtl/mul_arb_pkg.sv | 22 ++
 rtl/mul_arbiter_rr_pick.sv | 34 +++
 rtl/mul_arbiter.sv | 128 ++++++++++++
 tb/tb_mul_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and sizing helpers for the multiplier arbiter.
package mul_arb_pkg;

  typedef enum logic [2:0] {
    RESYNC  = 3'd0,
    IDLE    = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    DELIVER = 3'd4
  } state_t;

  localparam int DEFAULT_TIMEOUT = 32;

  // Ceiling log2, never below 1 so every counter/index has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational circular priority picker: first set req bit at or after ptr.
module rr_pick
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   idx
);

  logic [PW-1:0] idx_hi;
  logic [PW-1:0] idx_lo;
  logic          hit_hi;

  // Lowest set bit at/above ptr wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    hit_hi = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) idx_lo = PW'(i);
      if (req[i] && (i >= int'(ptr))) begin
        hit_hi = 1'b1;
        idx_hi = PW'(i);
      end
    end
    idx  = hit_hi ? idx_hi : idx_lo;
    pick = (|req) ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier between NREQ clients,
// with a watchdog on the multiplier and post-reset resynchronisation.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] ack,
  output logic [2*W-1:0]  result,
  output logic            err,
  output logic            mul_init,
  output logic [W-1:0]    mul_mr,
  output logic [W-1:0]    mul_md,
  input  logic            mul_done,
  input  logic [2*W-1:0]  mul_pp,
  output state_t          dbg_state
);

  localparam int PW = clog2(NREQ);
  localparam int DW = clog2(TIMEOUT + 1);

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] g_idx;
  logic [PW-1:0] pick_idx;
  logic [NREQ-1:0] pick;
  logic [DW-1:0] wdog;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  logic          wdog_hit;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == PW'(i)) begin
        sel_a = op_a[i*W +: W];
        sel_b = op_b[i*W +: W];
      end
    end
  end

  // The counter reaches TIMEOUT on the edge that leaves the current state.
  assign wdog_hit  = (wdog == DW'(TIMEOUT - 1));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESYNC;
      rr_ptr   <= '0;
      g_idx    <= '0;
      wdog     <= '0;
      gnt      <= '0;
      ack      <= '0;
      result   <= '0;
      err      <= 1'b0;
      mul_init <= 1'b0;
      mul_mr   <= '0;
      mul_md   <= '0;
    end else begin
      case (state)
        // Multiplier state is unknown after reset: wait for it to finish or give up.
        RESYNC: begin
          mul_init <= 1'b0;
          wdog     <= wdog + 1'b1;
          if (mul_done || wdog_hit) begin
            state <= IDLE;
            wdog  <= '0;
          end
        end
        IDLE: begin
          gnt <= '0;
          if (|req) begin
            gnt      <= pick;
            g_idx    <= pick_idx;
            mul_md   <= sel_a;
            mul_mr   <= sel_b;
            mul_init <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          mul_init <= 1'b0;
          wdog     <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wdog <= wdog + 1'b1;
          if (mul_done) begin
            result <= mul_pp;
            err    <= 1'b0;
            ack    <= gnt;
            state  <= DELIVER;
          end else if (wdog_hit) begin
            result <= '0;
            err    <= 1'b1;
            ack    <= gnt;
            state  <= DELIVER;
          end
        end
        DELIVER: begin
          ack    <= '0;
          gnt    <= '0;
          wdog   <= '0;
          rr_ptr <= (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
          state  <= err ? RESYNC : IDLE;
        end
        default: state <= RESYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a behavioural multiplier and requesters.
module tb_mul_arbiter;
  import mul_arb_pkg::*;

  localparam int NREQ    = 4;
  localparam int W       = 4;
  localparam int TIMEOUT = 32;
  localparam int PWD     = 2 * W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [PWD-1:0]    result;
  logic              err;
  logic              mul_init;
  logic [W-1:0]      mul_mr;
  logic [W-1:0]      mul_md;
  logic              mul_done;
  logic [PWD-1:0]    mul_pp;
  state_t            dbg_state;

  always #5 clk = ~clk;

  mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .ack       (ack),
    .result    (result),
    .err       (err),
    .mul_init  (mul_init),
    .mul_mr    (mul_mr),
    .mul_md    (mul_md),
    .mul_done  (mul_done),
    .mul_pp    (mul_pp),
    .dbg_state (dbg_state)
  );

  typedef struct {
    int             idx;
    logic [PWD-1:0] res;
    logic           err;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int init_cyc = 0;
  int ack_cyc  = 0;
  int m_ptr    = 0;
  int lat_sel  = 0;
  int inject_cnt  = 0;
  int inject_seen = 0;
  int mcnt = 0;
  int want[NREQ];
  int got[NREQ];
  logic [W-1:0]   ta[NREQ];
  logic [W-1:0]   tb[NREQ];
  logic [PWD-1:0] cap_a, cap_b;
  logic [PWD-1:0] last_res = '0;
  logic           last_err = 1'b0;
  logic           prev_init = 1'b0;
  logic           after_err = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  always @(posedge clk) cyc++;

  // Multiplier model: done after a chosen latency (lat_sel<0: never, 0: random).
  always @(negedge clk) begin
    if (!rst_n) begin
      mul_done = 1'b0;
      mcnt     = 0;
    end else begin
      mul_done = 1'b0;
      mul_pp   = PWD'($urandom);
      if (inject_cnt != inject_seen) begin
        inject_seen++;
        mul_done = 1'b1;
      end else if (mul_init) begin
        cap_a = PWD'(mul_md);
        cap_b = PWD'(mul_mr);
        if (lat_sel < 0) mcnt = 0;
        else if (lat_sel == 0) mcnt = int'($urandom_range(1, 3 * W + 2));
        else mcnt = lat_sel;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mul_done = 1'b1;
          mul_pp   = cap_a * cap_b;
        end
      end
    end
  end

  // Requesters hold req until their requested number of acks has arrived.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          got[i]++;
          if (got[i] >= want[i]) req[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every ack and checks issue-side outputs.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_res  = '0;
      last_err  = 1'b0;
      prev_init = 1'b0;
      after_err = 1'b0;
    end else begin
      if (mul_init) begin
        chk("init_single_pulse", 32'(prev_init), 0);
        if (exp_q.size() == 0) chk("unexpected_init", 32'(mul_init), 0);
        else begin
          chk("mul_md", 32'(mul_md), 32'(exp_q[0].a));
          chk("mul_mr", 32'(mul_mr), 32'(exp_q[0].b));
          chk("gnt_at_issue", 32'(gnt), 32'(1) << exp_q[0].idx);
        end
        if (after_err) begin
          chk("resync_cycles", cyc - ack_cyc, TIMEOUT + 2);
          after_err = 1'b0;
        end
        init_cyc = cyc;
      end
      prev_init = mul_init;
      if (ack != '0) begin
        if (exp_q.size() == 0) chk("unexpected_ack", 32'(ack), 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("ack_onehot", 32'(ack), 32'(1) << mon_e.idx);
          chk("gnt_at_ack", 32'(gnt), 32'(1) << mon_e.idx);
          chk("result", 32'(result), 32'(mon_e.res));
          chk("err", 32'(err), 32'(mon_e.err));
          if (mon_e.err) begin
            chk("timeout_wait_cycles", cyc - init_cyc - 1, TIMEOUT);
            after_err = 1'b1;
            ack_cyc   = cyc;
          end
          last_res = mon_e.res;
          last_err = mon_e.err;
        end
      end else begin
        chk("result_hold", 32'(result), 32'(last_res));
        chk("err_hold", 32'(err), 32'(last_err));
      end
    end
  end

  // Reference order: circular scan from the model pointer, repeated per round.
  task automatic issue(input logic [NREQ-1:0] mask, input bit exp_err, input int rounds);
    exp_t e;
    int   last;
    last = (m_ptr + NREQ - 1) % NREQ;
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (mask[i]) begin
          e.idx = i;
          e.a   = ta[i];
          e.b   = tb[i];
          e.err = exp_err;
          if (exp_err) e.res = '0;
          else e.res = PWD'(ta[i]) * PWD'(tb[i]);
          exp_q.push_back(e);
          last = i;
        end
      end
    end
    m_ptr = (last + 1) % NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        op_a[i*W +: W] = ta[i];
        op_b[i*W +: W] = tb[i];
        want[i] += rounds;
        req[i] = 1'b1;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      ta[i] = W'($urandom);
      tb[i] = W'($urandom);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: time %0t limit 2000000", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      want[i] = 0;
      got[i]  = 0;
      ta[i]   = '0;
      tb[i]   = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_mul_init", 32'(mul_init), 0);
    chk("rst_state", 32'(dbg_state), 32'(RESYNC));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("resync_waits", 32'(dbg_state), 32'(RESYNC));
    inject_cnt++;
    repeat (4) @(negedge clk);
    chk("resync_exit_on_done", 32'(dbg_state), 32'(IDLE));

    // Single request, then a filler so the pair below starts from pointer 0.
    ta[1] = 4'd3;  tb[1] = 4'd5;
    issue(4'b0010, 1'b0, 1); drain(200);
    ta[3] = 4'd6;  tb[3] = 4'd11;
    issue(4'b1000, 1'b0, 1); drain(200);
    ta[0] = 4'd7;  tb[0] = 4'd9;
    ta[2] = 4'd15; tb[2] = 4'd15;
    issue(4'b0101, 1'b0, 1); drain(400);

    // All requesters held continuously for three rounds.
    rand_ops();
    issue(4'b1111, 1'b0, 3); drain(1000);

    // Done on the last possible WAIT cycle wins; one cycle later is a timeout.
    lat_sel = TIMEOUT;
    ta[1] = 4'd15; tb[1] = 4'd15;
    issue(4'b0010, 1'b0, 1); drain(200);
    lat_sel = TIMEOUT + 1;
    rand_ops();
    issue(4'b0100, 1'b1, 1); drain(200);
    lat_sel = 0;
    rand_ops();
    issue(4'b0001, 1'b0, 1); drain(200);

    // Dead multiplier, then recovery through a full RESYNC.
    lat_sel = -1;
    rand_ops();
    issue(4'b1000, 1'b1, 1); drain(200);
    lat_sel = 0;
    rand_ops();
    issue(4'b0011, 1'b0, 1); drain(300);

    // Operand change while the operation is in flight.
    lat_sel = 10;
    ta[2] = 4'd4; tb[2] = 4'd2;
    issue(4'b0100, 1'b0, 1);
    repeat (4) @(negedge clk);
    op_a[2*W +: W] = 4'd9;
    drain(200);
    lat_sel = 0;

    // Reset during WAIT, stale done absorbed in RESYNC, done in IDLE ignored.
    lat_sel = -1;
    ta[0] = 4'd13; tb[0] = 4'd7;
    issue(4'b0001, 1'b0, 1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_result", 32'(result), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_mul_init", 32'(mul_init), 0);
    chk("midrst_mul_mr", 32'(mul_mr), 0);
    chk("midrst_mul_md", 32'(mul_md), 0);
    chk("midrst_state", 32'(dbg_state), 32'(RESYNC));
    exp_q.delete();
    req = '0;
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) want[i] = got[i];
    @(negedge clk);
    rst_n   = 1'b1;
    lat_sel = 0;
    @(negedge clk);
    inject_cnt++;
    repeat (4) @(negedge clk);
    chk("stale_done_to_idle", 32'(dbg_state), 32'(IDLE));
    inject_cnt++;
    repeat (4) @(negedge clk);
    ta[2] = 4'd0;  tb[2] = 4'd12;
    ta[3] = 4'd15; tb[3] = 4'd1;
    issue(4'b1100, 1'b0, 1); drain(300);

    // Randomised batches.
    for (int t = 0; t < 40; t++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      rand_ops();
      issue(m, 1'b0, 1);
      drain(600);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
